// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry TX FIFO.
// Register window: TXDATA at offset 0, STATUS at offset 4.
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 234
) (
    input  logic        clk,
    input  logic        i_resetn,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_rw,
    output logic [31:0] o_mem_data,
    output logic        o_sel,
    output logic        o_tx
);
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [7:0]  fifo_mem [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        rw_prev_q;
    logic [31:0] rdata_q, rdata_d;

    logic wr_fire, tx_wr, st_wr, pop, push;
    logic fifo_full, fifo_empty, busy, bit_end;
    logic unused_bits;

    assign unused_bits = ^{i_mem_data[31:8], i_mem_addr[1:0]};

    assign o_sel      = (i_mem_addr[31:4] == BASE_ADDR[31:4]);
    // Only the rising edge of rw counts, so a multi-cycle store pushes once.
    assign wr_fire    = o_sel && i_mem_rw && !rw_prev_q;
    assign tx_wr      = wr_fire && (i_mem_addr[3:2] == 2'd0);
    assign st_wr      = wr_fire && (i_mem_addr[3:2] == 2'd1);
    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign busy       = (state_q != StIdle);
    assign bit_end    = (baud_q == BaudLast);
    assign pop        = !fifo_empty && ((state_q == StIdle) || (state_q == StStop && bit_end));
    assign push       = tx_wr && (!fifo_full || pop);

    always_comb begin
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        ovf_d   = ovf_q;
        if (st_wr) begin
            ovf_d = 1'b0;
        end else if (tx_wr && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        if (o_sel) begin
            unique case (i_mem_addr[3:2])
                2'd0:    rdata_d = {30'd0, fifo_full, busy};
                2'd1:    rdata_d = {28'd0, ovf_q, fifo_empty, fifo_full, busy};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != StIdle) begin
            baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StStart;
                    shift_d = fifo_mem[rd_ptr_q];
                    baud_d  = 16'd0;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (pop) begin
                        state_d = StStart;
                        shift_d = fifo_mem[rd_ptr_q];
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q   <= StIdle;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            rd_ptr_q  <= 2'd0;
            wr_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
            rw_prev_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_ptr_q  <= pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
            wr_ptr_q  <= push ? wr_ptr_q + 2'd1 : wr_ptr_q;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rw_prev_q <= i_mem_rw;
            rdata_q   <= rdata_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_mem_data[7:0];
        end
    end

    assign o_tx       = tx_q;
    assign o_mem_data = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register table plus frame-level sequences,
// with a UART receiver model decoding o_tx.
module tb_uart_mmio;
    localparam int C = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] STAT = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        i_resetn = 1'b0;
    logic [31:0] i_mem_addr = 32'd0;
    logic [31:0] i_mem_data = 32'd0;
    logic        i_mem_rw = 1'b0;
    logic [31:0] o_mem_data;
    logic        o_sel;
    logic        o_tx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_edge = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] data;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[12];

    uart_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .i_resetn   (i_resetn),
        .i_mem_addr (i_mem_addr),
        .i_mem_data (i_mem_data),
        .i_mem_rw   (i_mem_rw),
        .o_mem_data (o_mem_data),
        .o_sel      (o_sel),
        .o_tx       (o_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples mid-bit, records byte and start cycle.
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    int         mon_start = 0;
    int         mon_err = 0;
    logic [7:0] mon_shift = 8'd0;
    logic [7:0] rx_q[$];
    int         rx_cyc[$];

    always @(negedge clk) begin
        if (!i_resetn) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (!o_tx) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
                mon_start  <= cyc;
            end
        end else begin
            if (mon_cnt % C == C / 2) begin
                if (mon_cnt / C == 0) begin
                    if (o_tx) mon_err <= mon_err + 1;
                end else if (mon_cnt / C == 9) begin
                    if (!o_tx) mon_err <= mon_err + 1;
                end else begin
                    mon_shift[3'(mon_cnt / C - 1)] <= o_tx;
                end
            end
            if (mon_cnt == 10 * C - 1) begin
                rx_q.push_back(mon_shift);
                rx_cyc.push_back(mon_start);
                mon_active <= 1'b0;
            end else begin
                mon_cnt <= mon_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        i_mem_addr = addr;
        i_mem_data = data;
        i_mem_rw   = 1'b1;
        tick();
        last_edge = cyc;
        tick();
        i_mem_rw = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        i_mem_addr = addr;
        i_mem_rw   = 1'b0;
        tick();
        data = o_mem_data;
    endtask

    task automatic wait_frames(input int n, input string name);
        int budget = 0;
        while (rx_q.size() < n && budget < 1000) begin
            tick();
            budget++;
        end
        check(name, rx_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        logic [7:0]  exp_b[6];
        logic        exp_bit;
        int          base;
        int          e0;

        vecs[0]  = '{STAT,          1'b0, 32'h0,  1'b1, 32'h4};
        vecs[1]  = '{32'h0000_2000, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[2]  = '{BASE,          1'b0, 32'h0,  1'b1, 32'h0};
        vecs[3]  = '{STAT,          1'b0, 32'h0,  1'b1, 32'h4};
        vecs[4]  = '{32'h0000_1008, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[5]  = '{STAT,          1'b0, 32'h0,  1'b1, 32'h4};
        vecs[6]  = '{32'h0000_1010, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[7]  = '{32'h0000_100C, 1'b0, 32'h0,  1'b1, 32'h0};
        vecs[8]  = '{32'h0000_1008, 1'b1, 32'hFF, 1'b1, 32'h0};
        vecs[9]  = '{STAT,          1'b1, 32'h12, 1'b1, 32'h4};
        vecs[10] = '{32'h0000_100C, 1'b1, 32'h41, 1'b1, 32'h0};
        vecs[11] = '{32'h0000_0FFC, 1'b0, 32'h0,  1'b0, 32'h0};

        // Reset state
        repeat (3) tick();
        check("reset_tx", o_tx, 1);
        check("reset_rdata", o_mem_data, 0);
        check("reset_sel_addr0", o_sel, 0);
        #3 i_resetn = 1'b1;
        tick();

        // Register table (idle, FIFO empty)
        for (int i = 0; i < 12; i++) begin
            i_mem_addr = vecs[i].addr;
            i_mem_data = vecs[i].data;
            i_mem_rw   = vecs[i].rw;
            #1;
            check($sformatf("vec%0d_sel", i), o_sel, vecs[i].exp_sel);
            tick();
            check($sformatf("vec%0d_rdata", i), o_mem_data, vecs[i].exp_rdata);
            i_mem_rw = 1'b0;
            tick();
        end
        repeat (4) tick();
        check("table_no_frame", rx_q.size(), 0);
        check("table_tx_idle", o_tx, 1);

        // Single byte 0x41, checked every cycle of the frame
        b = 8'h41;
        i_mem_addr = BASE;
        i_mem_data = 32'h41;
        i_mem_rw   = 1'b1;
        tick();
        check("single_tx_at_accept", o_tx, 1);
        tick();
        i_mem_rw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < C; c++) begin
                exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                check($sformatf("single_bit%0d_c%0d", k, c), o_tx, exp_bit);
                tick();
            end
        end
        bus_read(STAT, rd);
        check("single_status_idle", rd, 32'h4);
        repeat (30) tick();
        check("single_one_frame", rx_q.size(), 1);
        check("single_byte", rx_q[0], 8'h41);

        // Back-to-back frames
        base = rx_q.size();
        bus_write(BASE, 32'h55);
        bus_write(BASE, 32'hAA);
        bus_write(BASE, 32'h0F);
        wait_frames(base + 2, "b2b_two_frames");
        tick();
        tick();
        bus_read(STAT, rd);
        check("b2b_status_last_pop", rd, 32'h5);
        wait_frames(base + 3, "b2b_three_frames");
        check("b2b_byte0", rx_q[base], 8'h55);
        check("b2b_byte1", rx_q[base+1], 8'hAA);
        check("b2b_byte2", rx_q[base+2], 8'h0F);
        check("b2b_gap01", rx_cyc[base+1] - rx_cyc[base], 10 * C);
        check("b2b_gap12", rx_cyc[base+2] - rx_cyc[base+1], 10 * C);
        repeat (3) tick();
        bus_read(STAT, rd);
        check("b2b_status_done", rd, 32'h4);

        // Overflow: 6 writes during the first frame
        base = rx_q.size();
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) bus_write(BASE, {24'd0, exp_b[i]});
        bus_read(STAT, rd);
        check("ovf_status", rd, 32'hB);
        bus_read(BASE, rd);
        check("ovf_txdata_read", rd, 32'h3);
        bus_write(STAT, 32'h0);
        bus_read(STAT, rd);
        check("ovf_cleared", rd, 32'h3);
        wait_frames(base + 5, "ovf_five_frames");
        repeat (60) tick();
        check("ovf_sixth_dropped", rx_q.size(), base + 5);
        for (int i = 0; i < 5; i++) check($sformatf("ovf_byte%0d", i), rx_q[base+i], exp_b[i]);
        bus_read(STAT, rd);
        check("ovf_status_done", rd, 32'h4);

        // Full FIFO plus write on the STOP-to-START edge
        base = rx_q.size();
        exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        bus_write(BASE, 32'hA1);
        e0 = last_edge;
        for (int i = 1; i < 5; i++) bus_write(BASE, {24'd0, exp_b[i]});
        while (cyc < e0 + 10 * C) tick();
        i_mem_addr = BASE;
        i_mem_data = 32'hA6;
        i_mem_rw   = 1'b1;
        tick();
        check("fullpop_accept_edge", cyc, e0 + 10 * C + 1);
        tick();
        i_mem_rw = 1'b0;
        bus_read(STAT, rd);
        check("fullpop_status", rd, 32'h3);
        wait_frames(base + 6, "fullpop_six_frames");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fullpop_byte%0d", i), rx_q[base+i], exp_b[i]);
        end
        check("fullpop_gap45", rx_cyc[base+5] - rx_cyc[base+4], 10 * C);
        repeat (3) tick();
        bus_read(STAT, rd);
        check("fullpop_status_done", rd, 32'h4);

        // Reset mid-frame with two bytes queued
        base = rx_q.size();
        bus_write(BASE, 32'hF0);
        e0 = last_edge;
        bus_write(BASE, 32'h01);
        bus_write(BASE, 32'h02);
        i_mem_addr = STAT;
        while (cyc < e0 + 16) tick();
        check("rst_tx_before", o_tx, 0);
        check("rst_rdata_before", o_mem_data, 32'h1);
        #2 i_resetn = 1'b0;
        #1;
        check("rst_tx_async", o_tx, 1);
        check("rst_rdata_async", o_mem_data, 0);
        repeat (3) tick();
        check("rst_tx_held", o_tx, 1);
        #3 i_resetn = 1'b1;
        tick();
        tick();
        bus_read(STAT, rd);
        check("rst_status_after", rd, 32'h4);
        repeat (100) tick();
        check("rst_no_frames", rx_q.size(), base);
        check("rst_tx_idle", o_tx, 1);

        // First write after reset release
        i_mem_addr = BASE;
        i_mem_data = 32'h3C;
        i_mem_rw   = 1'b1;
        tick();
        check("post_rst_tx_at_accept", o_tx, 1);
        tick();
        check("post_rst_tx_fall", o_tx, 0);
        i_mem_rw = 1'b0;
        wait_frames(base + 1, "post_rst_frame");
        check("post_rst_byte", rx_q[base], 8'h3C);
        repeat (5) tick();
        check("framing_errors", mon_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of register window (bits [3:0] zero).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 234, clock cycles per UART bit, legal range 2..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_mem_addr  input  32  CPU bus byte address.
REQ-006 SHALL have port i_mem_data  input  32  CPU write data; only [7:0] is used.
REQ-007 SHALL have port i_mem_rw  input  1  1=write, 0=read; held high by the CPU for 2 or more consecutive cycles per store.
REQ-008 SHALL have port o_mem_data  output  32  registered read data.
REQ-009 SHALL have port o_sel  output  1  combinational; high when i_mem_addr[31:4]==BASE_ADDR[31:4]; used by the SoC read mux.
REQ-010 SHALL have port o_tx  output  1  UART serial out, 8N1, LSB first, idle high.

Function
REQ-011 SHALL decode offset i_mem_addr[3:2]: 0=TXDATA, 1=STATUS; offsets 2 and 3 read 0 and ignore writes.
REQ-012 SHALL accept a write only on the first cycle with o_sel=1, i_mem_rw=1 and registered previous i_mem_rw=0; further high cycles of the same store are ignored.
REQ-013 TXDATA write SHALL push i_mem_data[7:0] into a 4-entry FIFO, with wrapping 2-bit read and write pointers and a 3-bit count.
REQ-014 TXDATA write with count==4 and no same-cycle pop SHALL drop the byte and set sticky flag ovf.
REQ-015 TXDATA write with count==4 and a same-cycle pop SHALL be accepted; count stays 4.
REQ-016 STATUS write (any data) SHALL clear ovf; it has no other effect.
REQ-017 STATUS read value SHALL be {28'b0, ovf, empty(count==0), full(count==4), busy(state!=IDLE)}.
REQ-018 TXDATA read value SHALL be {30'b0, full, busy}.
REQ-019 o_mem_data SHALL update every edge from the current i_mem_addr (1-cycle latency) and SHALL be 0 when o_sel=0.
REQ-020 Transmitter SHALL be an FSM with states IDLE, START, DATA, STOP, a 16-bit baud counter and a 3-bit bit index.
REQ-021 IDLE with count>0: the FSM SHALL pop the head into a shift register, go to START and drive o_tx=0 from that edge.
REQ-022 Each of START, the 8 DATA bits and STOP SHALL last exactly CLKS_PER_BIT cycles; DATA SHALL drive shift[0] and shift right per bit; STOP SHALL drive 1.
REQ-023 At the end of STOP, the FSM SHALL pop and go directly to START if count>0 (no idle gap between frames), else go to IDLE.
REQ-024 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-025 For a write accepted at edge E0 with the FIFO empty and FSM in IDLE, o_tx SHALL fall at edge E0+1.
REQ-026 A write to the FIFO SHALL never corrupt the frame in progress; the shift register is loaded only on pop.

Reset
REQ-027 On i_resetn=0, immediately and regardless of clk, the block SHALL set: o_tx=1, o_mem_data=0, FSM=IDLE, FIFO pointers and count=0, ovf=0, baud counter and bit index=0, previous-rw register=0.
REQ-028 Reset mid-frame SHALL abort the frame (o_tx high at once) and discard all queued bytes.
REQ-029 After release, the first write accepted SHALL behave per REQ-025.

Verification (CLKS_PER_BIT=4, BASE_ADDR=0x1000)
REQ-030 Single byte: write 0x41 to 0x1000 (rw high 2 cycles) -> o_tx low at E0+1, bits 1,0,0,0,0,0,1,0 then stop, each 4 cycles, 40 cycles total, busy returns 0; one byte sent, not two.
REQ-031 Back-to-back: write 0x55, 0xAA, 0x0F -> three contiguous frames, no idle cycles between them, empty=1 after the last pop.
REQ-032 Overflow: write 6 bytes during the first frame -> bytes 1-5 sent (1 in flight + 4 queued), 6th dropped, STATUS reads 0xB (ovf, full, busy) before the next pop; STATUS write clears ovf.
REQ-033 Readback: read 0x1004 idle -> o_mem_data=0x4 one cycle later; read 0x2000 -> o_sel=0, o_mem_data=0.
REQ-034 Reset mid-frame: assert i_resetn=0 at frame cycle 15 with 2 bytes queued -> o_tx=1 asynchronously, STATUS=0x4 after release, no further frames.
REQ-035 Full plus pop: count=4 and a write lands on the STOP-to-START edge -> byte accepted, ovf stays 0, all 5 bytes sent in order.
